// File: rtl/spinet_pkg.sv
// Shared definitions for the SPI ring endpoint: packet layout, widths and frame FSM encoding.
package spinet_pkg;

  localparam int unsigned PKT_W  = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BCNT_W = 5;

  localparam logic [BCNT_W-1:0] BCNT_FRAME = BCNT_W'(16);
  localparam logic [BCNT_W-1:0] BCNT_SAT   = BCNT_W'(17);

  // Field positions: [15] valid, [14] reserved, [13:11] dest, [10:8] src, [7:0] payload.
  typedef struct packed {
    logic              valid;
    logic              rsvd;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] src;
    logic [7:0]        payload;
  } pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } frame_state_e;

endpackage

// File: rtl/spinet_fifo.sv
// Small valid/ready FIFO; a push and pop in the same cycle both take effect, even when full.
module spinet_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             not_full_q, not_empty_q;
  logic             push_c, pop_c;

  assign pop_c  = rd_ready_i && not_empty_q;
  assign push_c = wr_valid_i && (not_full_q || pop_c);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Flags are registered from the next occupancy so they track cnt_q exactly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      not_full_q  <= 1'b1;
      not_empty_q <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q       <= cnt_d;
      not_full_q  <= (cnt_d != CNT_W'(DEPTH));
      not_empty_q <= (cnt_d != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign wr_ready_o = not_full_q;
  assign rd_valid_o = not_empty_q;
  assign rd_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/spi_endpoint.sv
// SPI slave bridging an external host to the ring: host frames go to TX, ring packets to RX.
module spi_endpoint
  import spinet_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR  = 3'd0,
  parameter int unsigned       DEPTH = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic             txrdy,
  output logic             rxrdy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_data
);

  logic [2:0] sck_q, ss_q;
  logic [1:0] mosi_q;
  logic       sck_rise_c, sck_fall_c, ss_fall_c, ss_rise_c;

  frame_state_e      state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [PKT_W-1:0]  rx_sr_q, rx_sr_d;
  logic [PKT_W-1:0]  tx_sr_q, tx_sr_d;
  logic              had_rx_q, had_rx_d;
  logic              miso_q, miso_d;
  logic              tx_push_c, rx_pop_c;
  pkt_t              stamp_c;

  logic              rx_valid_c, rx_push_c;
  logic [PKT_W-1:0]  rx_head_c;

  // Two sync stages plus one history stage for edge detection; idle values avoid false edges.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sck_q  <= 3'b000;
      ss_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ss_q   <= {ss_q[1:0], ss};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sck_rise_c = sck_q[1] && !sck_q[2];
  assign sck_fall_c = !sck_q[1] && sck_q[2];
  assign ss_fall_c  = !ss_q[1] && ss_q[2];
  assign ss_rise_c  = ss_q[1] && !ss_q[2];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      bcnt_q   <= '0;
      rx_sr_q  <= '0;
      tx_sr_q  <= '0;
      had_rx_q <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      rx_sr_q  <= rx_sr_d;
      tx_sr_q  <= tx_sr_d;
      had_rx_q <= had_rx_d;
      miso_q   <= miso_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    had_rx_d  = had_rx_q;
    tx_push_c = 1'b0;
    rx_pop_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tx_sr_d  = rx_valid_c ? rx_head_c : '0;
        had_rx_d = rx_valid_c;
        rx_sr_d  = '0;
        bcnt_d   = '0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ss_rise_c) begin
          state_d = ST_DONE;
        end else begin
          if (sck_rise_c) begin
            rx_sr_d = {rx_sr_q[PKT_W-2:0], mosi_q[1]};
            if (bcnt_q != BCNT_SAT) bcnt_d = bcnt_q + BCNT_W'(1);
          end
          if (sck_fall_c) tx_sr_d = {tx_sr_q[PKT_W-2:0], 1'b0};
        end
      end
      ST_DONE: begin
        // Only an exact 16-bit frame commits; the RX head is released only once delivered.
        if (bcnt_q == BCNT_FRAME) begin
          rx_pop_c  = had_rx_q;
          tx_push_c = rx_sr_q[PKT_W-1];
        end
        tx_sr_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    miso_d = (state_d != ST_IDLE) ? tx_sr_d[PKT_W-1] : 1'b0;
  end

  always_comb begin
    stamp_c     = pkt_t'(rx_sr_q);
    stamp_c.src = ADDR;
  end

  assign rx_push_c = in_valid && in_ready;

  spinet_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .wr_valid_i (tx_push_c),
    .wr_ready_o (txrdy),
    .wr_data_i  (PKT_W'(stamp_c)),
    .rd_valid_o (out_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (out_data)
  );

  spinet_fifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .wr_valid_i (rx_push_c),
    .wr_ready_o (in_ready),
    .wr_data_i  (in_data),
    .rd_valid_o (rx_valid_c),
    .rd_ready_i (rx_pop_c),
    .rd_data_o  (rx_head_c)
  );

  assign rxrdy = rx_valid_c;
  assign miso  = miso_q;

endmodule

// File: tb/tb_spi_endpoint.sv
// Bench for spi_endpoint: a table of host/ring transactions plus hand-written corner sequences.
module tb_spi_endpoint;

  localparam int unsigned DEPTH = 2;
  localparam int SPH = 6;

  logic clk = 1'b0;
  logic rst;
  logic sck, mosi, ss0, ss1;
  logic miso0, miso1;
  logic txrdy0, rxrdy0, out_valid0, out_ready0, in_ready0, in_valid0;
  logic txrdy1, rxrdy1, out_valid1, out_ready1, in_ready1, in_valid1;
  logic [15:0] out_data0, in_data0, out_data1, in_data1;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] sb0[$], sb1[$], obs0[$], obs1[$];

  typedef struct {
    logic [15:0] host;
    logic        ring_en;
    logic [15:0] ring;
    logic        out_en;
    logic [15:0] out_exp;
    logic [15:0] miso_exp;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  spi_endpoint #(.ADDR(3'd0), .DEPTH(DEPTH)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .sck(sck), .ss(ss0), .mosi(mosi), .miso(miso0),
    .txrdy(txrdy0), .rxrdy(rxrdy0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0)
  );

  spi_endpoint #(.ADDR(3'd5), .DEPTH(DEPTH)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .sck(sck), .ss(ss1), .mosi(mosi), .miso(miso1),
    .txrdy(txrdy1), .rxrdy(rxrdy1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance n cycles; output handshakes are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (out_valid0 && out_ready0) obs0.push_back(out_data0);
      if (out_valid1 && out_ready1) obs1.push_back(out_data1);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic flush_obs();
    while (obs0.size() != 0) begin
      if (sb0.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL out0_unexpected: got %h, expected nothing", obs0.pop_front());
      end else check("out0_data", obs0.pop_front(), sb0.pop_front());
    end
    while (obs1.size() != 0) begin
      if (sb1.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL out1_unexpected: got %h, expected nothing", obs1.pop_front());
      end else check("out1_data", obs1.pop_front(), sb1.pop_front());
    end
  endtask

  task automatic drain();
    int budget = 400;
    flush_obs();
    while ((sb0.size() != 0 || sb1.size() != 0) && budget > 0) begin
      tick(1);
      budget--;
      flush_obs();
    end
    tick(6);
    flush_obs();
    check("scoreboard_empty", 16'(sb0.size() + sb1.size()), 16'h0000);
    sb0.delete();
    sb1.delete();
  endtask

  task automatic ring_push(input logic [15:0] w);
    bit done = 1'b0;
    in_valid0 = 1'b1;
    in_data0  = w;
    for (int k = 0; k < 50 && !done; k++) begin
      if (in_ready0) done = 1'b1;
      tick(1);
    end
    in_valid0 = 1'b0;
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL ring_push_timeout: in_ready stayed %b, expected 1", in_ready0);
    end
  endtask

  task automatic spi_bits(input int which, input logic [15:0] w, input int n, output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[15-i];
      tick(SPH);
      sck = 1'b1;
      rd = {rd[14:0], (which == 0) ? miso0 : miso1};
      tick(SPH);
      sck = 1'b0;
    end
  endtask

  task automatic spi_xfer(input int which, input logic [15:0] w, input int n, output logic [15:0] rd);
    if (which == 0) ss0 = 1'b0; else ss1 = 1'b0;
    tick(SPH);
    spi_bits(which, w, n, rd);
    tick(SPH);
    if (which == 0) ss0 = 1'b1; else ss1 = 1'b1;
    tick(8);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_txrdy"},     16'(txrdy0),     16'h0001);
    check({tag, "_rxrdy"},     16'(rxrdy0),     16'h0000);
    check({tag, "_out_valid"}, 16'(out_valid0), 16'h0000);
    check({tag, "_in_ready"},  16'(in_ready0),  16'h0001);
    check({tag, "_miso"},      16'(miso0),      16'h0000);
  endtask

  initial begin
    logic [15:0] rd;
    vecs[0] = '{16'h9840, 1'b0, 16'h0000, 1'b1, 16'h9840, 16'h0000};
    vecs[1] = '{16'h0000, 1'b1, 16'h8305, 1'b0, 16'h0000, 16'h8305};
    vecs[2] = '{16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{16'hA7FF, 1'b1, 16'h1111, 1'b1, 16'hA0FF, 16'h1111};
    vecs[4] = '{16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'hF8FF, 16'h0000};
    vecs[5] = '{16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF};

    rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss0 = 1'b1; ss1 = 1'b1;
    out_ready0 = 1'b1; out_ready1 = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0; in_valid1 = 1'b0; in_data1 = '0;
    tick(4);
    check_reset("reset");
    rst = 1'b0;
    tick(4);

    foreach (vecs[i]) begin
      if (vecs[i].ring_en) begin
        ring_push(vecs[i].ring);
        tick(3);
        check("rxrdy_after_push", 16'(rxrdy0), 16'h0001);
      end
      if (vecs[i].out_en) sb0.push_back(vecs[i].out_exp);
      spi_xfer(0, vecs[i].host, 16, rd);
      check("host_read", rd, vecs[i].miso_exp);
      drain();
      check("rxrdy_after_frame", 16'(rxrdy0), 16'h0000);
    end

    // Short frame leaves the RX head in place for the next full frame.
    ring_push(16'h8AB1);
    tick(3);
    spi_xfer(0, 16'hC000, 10, rd);
    check("short_read", rd, 16'h022A);
    check("short_rxrdy", 16'(rxrdy0), 16'h0001);
    drain();
    spi_xfer(0, 16'h0000, 16, rd);
    check("retry_read", rd, 16'h8AB1);
    check("retry_rxrdy", 16'(rxrdy0), 16'h0000);
    drain();

    // TX overflow with the ring stalled.
    out_ready0 = 1'b0;
    for (int k = 0; k <= int'(DEPTH); k++) begin
      spi_xfer(0, 16'h8100 + 16'(k), 16, rd);
      if (k < int'(DEPTH)) sb0.push_back(16'h8000 + 16'(k));
      check("txrdy_fill", 16'(txrdy0), (k + 1 >= int'(DEPTH)) ? 16'h0000 : 16'h0001);
    end
    out_ready0 = 1'b1;
    drain();
    check("txrdy_drained", 16'(txrdy0), 16'h0001);
    check("out_valid_drained", 16'(out_valid0), 16'h0000);

    // Source stamping on a non-zero address.
    sb1.push_back(16'h8540);
    spi_xfer(1, 16'h8040, 16, rd);
    check("addr5_read", rd, 16'h0000);
    drain();

    // Reset in the middle of a frame.
    ss0 = 1'b0;
    tick(SPH);
    spi_bits(0, 16'h9840, 8, rd);
    rst = 1'b1;
    tick(3);
    ss0 = 1'b1;
    tick(3);
    check_reset("midrst");
    rst = 1'b0;
    tick(20);
    check_reset("postrst");
    sb0.push_back(16'h9001);
    spi_xfer(0, 16'h9001, 16, rd);
    check("postrst_read", rd, 16'h0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
